// File: rtl/wrap_counter_pkg.sv
// Shared calendar-field constants and small helpers for wrap_counter and its callers.
// Each field is a MIN/MAX/RESET triple passed to wrap_counter as parameters.
package wrap_counter_pkg;

    localparam int SEC_MIN     = 0;
    localparam int SEC_MAX     = 59;
    localparam int SEC_RESET   = 0;

    localparam int MIN_MIN     = 0;
    localparam int MIN_MAX     = 59;
    localparam int MIN_RESET   = 0;

    localparam int HOUR_MIN    = 0;
    localparam int HOUR_MAX    = 23;
    localparam int HOUR_RESET  = 0;

    localparam int DAY_MIN     = 1;
    localparam int DAY_MAX     = 31;
    localparam int DAY_RESET   = 1;

    localparam int MONTH_MIN   = 1;
    localparam int MONTH_MAX   = 12;
    localparam int MONTH_RESET = 1;

    localparam int YEAR_MIN    = 1;
    localparam int YEAR_MAX    = 60;
    localparam int YEAR_RESET  = 1;

    // One field description, handy for display code that walks all fields.
    typedef struct packed {
        logic [15:0] min_val;
        logic [15:0] max_val;
        logic [15:0] reset_val;
    } field_cfg_t;

    localparam field_cfg_t SEC_CFG   = '{16'(SEC_MIN),   16'(SEC_MAX),   16'(SEC_RESET)};
    localparam field_cfg_t MIN_CFG   = '{16'(MIN_MIN),   16'(MIN_MAX),   16'(MIN_RESET)};
    localparam field_cfg_t HOUR_CFG  = '{16'(HOUR_MIN),  16'(HOUR_MAX),  16'(HOUR_RESET)};
    localparam field_cfg_t DAY_CFG   = '{16'(DAY_MIN),   16'(DAY_MAX),   16'(DAY_RESET)};
    localparam field_cfg_t MONTH_CFG = '{16'(MONTH_MIN), 16'(MONTH_MAX), 16'(MONTH_RESET)};
    localparam field_cfg_t YEAR_CFG  = '{16'(YEAR_MIN),  16'(YEAR_MAX),  16'(YEAR_RESET)};

    // What the counter does in a given cycle, in priority order below clear.
    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_LOAD_ERR,
        ACT_UP,
        ACT_DOWN,
        ACT_CLAMP
    } step_act_e;

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/wrap_counter_if.sv
// Control/status bundle of one wrap_counter field; master drives requests, slave is the counter.
interface wrap_counter_if #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2
);
    logic                  load;
    logic [WIDTH-1:0]      data;
    logic                  tick;
    logic                  down;
    logic [WIDTH-1:0]      limit;
    logic                  oe;
    logic [WIDTH-1:0]      value;
    logic [WIDTH-1:0]      databus;
    logic [4*DIGITS-1:0]   bcd;
    logic                  carry;
    logic                  borrow;
    logic                  load_err;

    modport master (
        output load, data, tick, down, limit, oe,
        input  value, databus, bcd, carry, borrow, load_err
    );

    modport slave (
        input  load, data, tick, down, limit, oe,
        output value, databus, bcd, carry, borrow, load_err
    );
endinterface

// File: rtl/wrap_counter_bin2bcd.sv
// Combinational binary-to-BCD converter (double dabble); digit 0 sits in bcd[3:0].
module bin2bcd #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2
) (
    input  logic [WIDTH-1:0]    bin,
    output logic [4*DIGITS-1:0] bcd
);

    localparam int SW = 4 * DIGITS + WIDTH;

    function automatic logic [4*DIGITS-1:0] dabble(input logic [WIDTH-1:0] b);
        logic [SW-1:0] sr;
        sr = '0;
        sr[WIDTH-1:0] = b;
        for (int i = 0; i < WIDTH; i++) begin
            // Pre-correct any digit >= 5 so the following shift carries correctly.
            for (int d = 0; d < DIGITS; d++) begin
                if (sr[WIDTH + 4*d +: 4] >= 4'd5) begin
                    sr[WIDTH + 4*d +: 4] = sr[WIDTH + 4*d +: 4] + 4'd3;
                end
            end
            sr = sr << 1;
        end
        return sr[WIDTH +: 4*DIGITS];
    endfunction

    always_comb begin
        bcd = dabble(bin);
    end

endmodule

// File: rtl/wrap_counter.sv
// Generic calendar-field counter: counts MIN_VAL..eff_max up or down, wraps with a
// registered carry/borrow pulse, validates loads and clamps when the dynamic limit drops.
module wrap_counter
    import wrap_counter_pkg::*;
#(
    parameter int WIDTH     = 6,
    parameter int MIN_VAL   = 1,
    parameter int MAX_VAL   = 60,
    parameter int RESET_VAL = 1,
    parameter int USE_LIMIT = 0,
    parameter int DIGITS    = 2
) (
    input  logic         clk,
    input  logic         clear,
    wrap_counter_if.slave bus
);

    if ((MAX_VAL >> WIDTH) != 0) begin : g_err_max_width
        $fatal(1, "wrap_counter: MAX_VAL does not fit in WIDTH bits");
    end
    if (MIN_VAL > MAX_VAL) begin : g_err_min_max
        $fatal(1, "wrap_counter: MIN_VAL exceeds MAX_VAL");
    end
    if (RESET_VAL < MIN_VAL || RESET_VAL > MAX_VAL) begin : g_err_reset
        $fatal(1, "wrap_counter: RESET_VAL outside [MIN_VAL, MAX_VAL]");
    end
    if (pow10(DIGITS) <= longint'(MAX_VAL)) begin : g_err_digits
        $fatal(1, "wrap_counter: DIGITS too small for MAX_VAL");
    end

    localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] value_q, value_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             load_err_q, load_err_d;

    logic [WIDTH-1:0] lim_clip;
    logic [WIDTH-1:0] lim_floor;
    logic [WIDTH-1:0] eff_max;
    logic             data_below_min;
    logic             load_ok;
    step_act_e        act;

    assign lim_clip = (bus.limit < MAX_W) ? bus.limit : MAX_W;

    // With MIN_VAL = 0 the lower-bound checks are vacuous, so they are left out entirely.
    if (MIN_VAL > 0) begin : g_min_pos
        assign data_below_min = (bus.data < MIN_W);
        assign lim_floor      = (lim_clip < MIN_W) ? MIN_W : lim_clip;
    end else begin : g_min_zero
        assign data_below_min = 1'b0;
        assign lim_floor      = lim_clip;
    end

    assign eff_max = (USE_LIMIT != 0) ? lim_floor : MAX_W;
    assign load_ok = !data_below_min && (bus.data <= eff_max);

    always_comb begin
        act = ACT_HOLD;
        if (bus.load) begin
            act = load_ok ? ACT_LOAD : ACT_LOAD_ERR;
        end else if (bus.tick) begin
            act = bus.down ? ACT_DOWN : ACT_UP;
        end else if (value_q > eff_max) begin
            act = ACT_CLAMP;
        end
    end

    always_comb begin
        value_d    = value_q;
        carry_d    = 1'b0;
        borrow_d   = 1'b0;
        load_err_d = 1'b0;
        case (act)
            ACT_LOAD:     value_d = bus.data;
            ACT_LOAD_ERR: load_err_d = 1'b1;
            ACT_UP: begin
                // >= rather than == so a value left above a freshly lowered limit still wraps.
                if (value_q >= eff_max) begin
                    value_d = MIN_W;
                    carry_d = 1'b1;
                end else begin
                    value_d = value_q + WIDTH'(1);
                end
            end
            ACT_DOWN: begin
                if (value_q <= MIN_W) begin
                    value_d  = eff_max;
                    borrow_d = 1'b1;
                end else begin
                    value_d = value_q - WIDTH'(1);
                end
            end
            ACT_CLAMP:    value_d = eff_max;
            default:      value_d = value_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            value_q    <= RESET_W;
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            value_q    <= value_d;
            carry_q    <= carry_d;
            borrow_q   <= borrow_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.value    = value_q;
    assign bus.carry    = carry_q;
    assign bus.borrow   = borrow_q;
    assign bus.load_err = load_err_q;
    assign bus.databus  = bus.oe ? value_q : '0;

    logic [4*DIGITS-1:0] bcd_w;

    bin2bcd #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .bin (value_q),
        .bcd (bcd_w)
    );

    assign bus.bcd = bcd_w;

endmodule

// File: doc/wrap_counter.md
Name: wrap_counter

Overview:
Parametrised calendar-field counter that generalises the fixed year counter to any field: seconds, minutes, hours, day, month or year.
- Counts from MIN_VAL to an effective maximum, either static or runtime-supplied, up or down.
- Emits a registered carry/borrow pulse on wrap so fields can be chained.
- Validates loads and provides gated bus and BCD outputs for the display path.

Parameters:
WIDTH, 6, bit width of value/data/limit
MIN_VAL, 1, lowest legal value (0 for sec/min/hour, 1 for day/month/year)
MAX_VAL, 60, static upper bound; must be < 2**WIDTH
RESET_VAL, 1, value after clear; must lie in [MIN_VAL, MAX_VAL]
USE_LIMIT, 0, 1 = effective max also bounded by the limit port (day-of-month)
DIGITS, 2, BCD digits on bcd output; 10**DIGITS must exceed MAX_VAL

Ports:
clk  in  1  system clock, all state on posedge
clear  in  1  reset, synchronous, active-high
load  in  1  load request for data this cycle
data  in  WIDTH  value to load
tick  in  1  count enable, one step per asserted cycle
down  in  1  0 = count up, 1 = count down (sampled with tick)
limit  in  WIDTH  dynamic max; ignored when USE_LIMIT=0
oe  in  1  databus output enable
value  out  WIDTH  registered current count
databus  out  WIDTH  oe ? value : 0, combinational
bcd  out  4*DIGITS  combinational BCD of value, LS digit in [3:0]
carry  out  1  registered 1-cycle pulse: up-count wrapped eff_max->MIN_VAL
borrow  out  1  registered 1-cycle pulse: down-count wrapped MIN_VAL->eff_max
load_err  out  1  registered 1-cycle pulse: out-of-range load rejected

Behaviour:
- Reset is decided: one clock (clk); clear is synchronous, active-high.
- On clear: value=RESET_VAL; carry=0; borrow=0; load_err=0. Clear overrides all other inputs in that cycle.
- Effective max (combinational):
  - USE_LIMIT=0: eff_max = MAX_VAL.
  - USE_LIMIT=1: eff_max = min(limit, MAX_VAL), floored at MIN_VAL.
- Priority per cycle: clear > load > tick > clamp > hold.
- Load:
  - If MIN_VAL <= data <= eff_max, value<=data next cycle.
  - Otherwise value holds and load_err pulses for 1 cycle.
  - Any tick in the same cycle is discarded; no carry or borrow.
- Tick up (down=0):
  - value>=eff_max -> value<=MIN_VAL, carry<=1.
  - Else value<=value+1.
- Tick down (down=1):
  - value<=MIN_VAL -> value<=eff_max, borrow<=1.
  - Else value<=value-1.
- Clamp: no load and no tick, but value>eff_max (limit dropped, e.g. day 31 -> month of 30) -> value<=eff_max next cycle, no carry.
- carry, borrow and load_err are high for exactly one cycle per event and low otherwise. Back-to-back events give back-to-back pulses.
- Latency: value, carry and borrow update 1 cycle after the qualifying input. databus and bcd follow value combinationally (0 cycles).
- Arithmetic:
  - Comparisons are unsigned and WIDTH wide.
  - +1/-1 never overflows, because wrap is taken before the bound.
- BCD output: decimal conversion of value; digits above the needed count are 0.
- Elaboration: illegal parameter combinations (RESET_VAL out of range, MAX_VAL >= 2**WIDTH, 10**DIGITS <= MAX_VAL, MIN_VAL > MAX_VAL) raise a fatal elaboration error.

Decomposition:
- Shared clock package holds field constants: SEC (0..59), MIN (0..59), HOUR (0..23), DAY (1..31), MONTH (1..12), YEAR (1..60), each as MIN/MAX/RESET triples. Callers instantiate wrap_counter with these triples.
- One sub-module, bin2bcd: parameters WIDTH and DIGITS; purely combinational double-dabble or divide/modulo, reused by display code.
- Chaining (carry -> tick of the next field) is done by the caller, not inside this block.

Test Plan:
1. Defaults (MIN=1, MAX=60, RESET=1): clear, then 60 ticks up -> value 1..60 then 1. carry high exactly the cycle after the 60th tick; bcd=8'h60 at value 60.
2. down=1 from value 1, one tick -> value 60, borrow pulse 1 cycle, carry stays 0. Next down tick -> 59, borrow 0.
3. load data=45 -> value 45 next cycle, no load_err. Then load data=0 and data=61 -> value stays 45, load_err pulses each. load=1 with tick=1 -> tick ignored.
4. USE_LIMIT=1, MIN=1, MAX=31, value 31; limit drops 31->30 with no tick -> value 30 next cycle, no carry. Tick -> value 1, carry pulse. limit=0 -> eff_max=1, tick keeps value 1 and pulses carry.
5. clear asserted together with load=1 data=20 and tick=1 -> value=RESET_VAL, all pulses 0. oe=0 -> databus=0; oe=1 -> databus=value.
6. MIN=0, MAX=59, RESET=0: 59 -> tick -> 0 with carry. Continuous tick for 120 cycles -> exactly 2 carry pulses.
